// File: rtl/nn_frame_loader.sv
// Host byte loader: captures strobed bytes into one frame buffer, then streams it out.
// Optional running checksum of committed bytes when NN_LOADER_CHECKSUM_EN is defined.
module nn_frame_loader #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 16,
  parameter int PTR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_strobe,
  input  logic              frame_start,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [7:0]        checksum
);

  typedef enum logic [0:0] {LOAD, STREAM} state_t;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

  state_t            state, state_nxt;
  logic              s1, s2, s3;
  logic              commit, load_commit, wr_last, handshake, last_hs;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] frame_mem [FRAME_LEN];

  // Rising edge of the synchronized strobe; a held strobe commits once.
  assign commit      = s2 & ~s3;
  assign load_commit = commit & (state == LOAD) & ~frame_start;
  assign wr_last     = load_commit & (wr_ptr == LAST_IDX);
  assign handshake   = (state == STREAM) & out_ready;
  assign last_hs     = handshake & (rd_ptr == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      LOAD: begin
        if (wr_last) state_nxt = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = frame_mem[rd_ptr];
        out_last  = (rd_ptr == LAST_IDX);
        if (last_hs) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
    if (frame_start) state_nxt = LOAD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      s1         <= wr_strobe;
      s2         <= s1;
      s3         <= s2;
      frame_done <= last_hs & ~frame_start;
      if (frame_start) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (load_commit) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        if (commit && state == STREAM) overflow <= 1'b1;
        if (handshake) rd_ptr <= last_hs ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  // Buffer is data only: not reset, and left intact by frame_start.
  always_ff @(posedge clk) begin
    if (load_commit) frame_mem[wr_ptr] <= wr_data;
  end

`ifdef NN_LOADER_CHECKSUM_EN
  logic [7:0] csum_acc;

  function automatic logic [7:0] add_mod256(input logic [7:0] acc, input logic [DATA_W-1:0] d);
    return acc + 8'(d);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || frame_start || last_hs) csum_acc <= '0;
    else if (load_commit)                csum_acc <= add_mod256(csum_acc, wr_data);
  end

  assign checksum = busy ? csum_acc : 8'h00;
`else
  assign checksum = 8'h00;
`endif

endmodule
